// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
//   byte_t  : one UART payload byte
//   rr_next : round-robin index increment with wrap
`timescale 1ns/1ps
package uart_tx_arbiter_pkg;

  typedef logic [7:0] byte_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin selector: picks the first set request bit, searching upward
// from `pointer` with wrap.
//   request : one bit per requester
//   pointer : index holding highest priority this cycle
//   grant   : one-hot winner (all zero when no request)
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IW'((32'(pointer) + 32'(off)) % NUM_REQ);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte streams onto a single uart_tx. A requester holds the
// transmitter for a whole message (until its last byte is sent) or until it
// stalls for IDLE_TIMEOUT consecutive cycles.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/data/last_i : per-lane byte stream (lane i = data bits [8i+7:8i])
//   req_ready_o           : per-lane accept, only ever on the granted lane
//   data_o, tx_en_o       : byte and enable towards uart_tx
//   tx_ready              : uart_tx can take a byte this cycle
//   grant_o, busy_o       : one-hot current owner, high while a grant is held
//   timeout_o             : one-cycle pulse when a stalled grant is revoked
`timescale 1ns/1ps
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           data_o,
  output logic                 tx_en_o,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam logic [CW-1:0] STALL_MAX = CW'(IDLE_TIMEOUT);

  logic               state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, rr_grant;
  logic [IW-1:0]      ptr_q, rr_idx;
  logic [CW-1:0]      stall_q;
  logic               timeout_q;
  logic               g_valid, g_last, xfer, stall_hit;
  byte_t              g_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .request (req_valid_i),
    .pointer (ptr_q),
    .grant   (rr_grant)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (rr_grant[i]) rr_idx = IW'(i);
  end

  // Granted-lane view; grant_q is one-hot so the mux never sees two lanes.
  always_comb begin
    g_data  = '0;
    g_valid = |(req_valid_i & grant_q);
    g_last  = |(req_valid_i & req_last_i & grant_q);
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) g_data = req_data_i[8*i +: 8];
  end

  assign xfer      = (state_q == ST_BUSY) && g_valid && tx_ready;
  // Fires on the stalled cycle that brings the count up to IDLE_TIMEOUT.
  assign stall_hit = (state_q == ST_BUSY) && !g_valid && (stall_q == STALL_MAX - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req_valid_i) state_d = ST_BUSY;
      ST_BUSY: if ((xfer && g_last) || stall_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, priority pointer and stall counter. The pointer moves past the
  // winner at grant time, so a revoked grant is already skipped next round.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q   <= '0;
      ptr_q     <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_hit;
      if (state_q == ST_IDLE) begin
        stall_q <= '0;
        if (|req_valid_i) begin
          grant_q <= rr_grant;
          ptr_q   <= IW'(rr_next(32'(rr_idx), NUM_REQ));
        end
      end else if (state_d == ST_IDLE) begin
        grant_q <= '0;
        stall_q <= '0;
      end else if (g_valid) begin
        stall_q <= '0;
      end else if (stall_q != STALL_MAX) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Outputs; reset masks them combinationally so an in-flight byte is
  // abandoned in the very cycle reset rises.
  always_comb begin
    tx_en_o     = 1'b0;
    data_o      = '0;
    req_ready_o = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    timeout_o   = timeout_q && !reset;
    if (!reset && state_q == ST_BUSY) begin
      tx_en_o     = g_valid;
      data_o      = g_data;
      req_ready_o = grant_q & req_valid_i & {NUM_REQ{tx_ready}};
      grant_o     = grant_q;
      busy_o      = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     data_o;
  logic           tx_en_o;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .data_o(data_o), .tx_en_o(tx_en_o),
    .tx_ready(tx_ready), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] lbuf [N][64];
  int         ltail [N] = '{default: 0};
  int         lhead [N] = '{default: 0};
  int         mode = 0;        // 0: tx_ready low, 1: always high, 2: every 4th cycle
  int         flush_req = 0, drv_ack = 0, mon_ack = 0;
  int         xfer_cnt = 0, cyc = 0;
  int         passes = 0, checks = 0;
  logic [N-1:0] drv_acc;
  logic         bubble = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Stimulus: queue a byte on a lane and its expected appearance at uart_tx.
  task automatic load(input int lane, input logic [7:0] b, input logic last);
    exp_t e;
    lbuf[lane][ltail[lane]] = {last, b};
    ltail[lane]++;
    e.last = last; e.lane = 2'(lane); e.data = b;
    exp_q.push_back(e);
  endtask

  // Requester model: pops a lane when its ready was high at the edge.
  initial begin
    forever begin
      @(negedge clk);
      drv_acc = req_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      if (flush_req != drv_ack) begin
        for (int i = 0; i < N; i++) lhead[i] = ltail[i];
        drv_ack = flush_req;
      end else begin
        for (int i = 0; i < N; i++)
          if (drv_acc[i] && lhead[i] < ltail[i]) lhead[i]++;
      end
      for (int i = 0; i < N; i++) begin
        req_valid_i[i]       = lhead[i] < ltail[i];
        req_data_i[8*i +: 8] = req_valid_i[i] ? lbuf[i][lhead[i]][7:0] : 8'h00;
        req_last_i[i]        = req_valid_i[i] ? lbuf[i][lhead[i]][8] : 1'b0;
      end
      tx_ready = (mode == 1) || (mode == 2 && (cyc % 4) == 0);
    end
  end

  // Monitor: every byte handed to uart_tx is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (flush_req != mon_ack) begin
        exp_q.delete();
        mon_ack = flush_req;
        bubble  = 1'b0;
      end
      if (bubble) begin
        chk("bubble_busy", 32'(busy_o), 32'd0);
        bubble = 1'b0;
      end
      if (tx_en_o && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("xfer_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(data_o), 32'(e.data));
          chk("grant", 32'(grant_o), 32'd1 << e.lane);
          chk("ready", 32'(req_ready_o), 32'd1 << e.lane);
          chk("busy", 32'(busy_o), 32'd1);
          bubble = e.last;
        end
      end
    end
  end

  task automatic start_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    flush_req++;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_xfers(input string name, input int target);
    int n = 0;
    while (xfer_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_tx_en"},   32'(tx_en_o), 32'd0);
    chk({pfx, "_ready"},   32'(req_ready_o), 32'd0);
    chk({pfx, "_grant"},   32'(grant_o), 32'd0);
    chk({pfx, "_busy"},    32'(busy_o), 32'd0);
    chk({pfx, "_timeout"}, 32'(timeout_o), 32'd0);
    chk({pfx, "_data"},    32'(data_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, bad_d, bad_g, bad_r, bad_t;
    logic [7:0]   snap_d;
    logic [N-1:0] snap_g;

    // Contention: lanes 0 and 1 valid while still in reset.
    mode = 1;
    repeat (2) @(posedge clk);
    load(0, 8'hA0, 1'b0); load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    load(1, 8'hB0, 1'b0); load(1, 8'hB1, 1'b0); load(1, 8'hB2, 1'b1);
    @(negedge clk);
    chk_zero("reset");
    release_reset();
    wait_drain("contention_drain", 100);

    // Single requester, tx_ready pulsed every 4 cycles.
    start_reset();
    mode = 2;
    load(0, 8'h48, 1'b0); load(0, 8'h69, 1'b0); load(0, 8'h0D, 1'b0); load(0, 8'h0A, 1'b1);
    release_reset();
    wait_drain("hi_drain", 100);

    // Fairness: three lanes, 1-byte messages, grants 0,1,2,0,1,2.
    start_reset();
    mode = 1;
    load(0, 8'h10, 1'b1); load(1, 8'h11, 1'b1); load(2, 8'h12, 1'b1);
    load(0, 8'h20, 1'b1); load(1, 8'h21, 1'b1); load(2, 8'h22, 1'b1);
    release_reset();
    wait_drain("fair_drain", 100);

    // Timeout: lane 1 sends one byte without last, then goes quiet.
    start_reset();
    mode = 1;
    load(1, 8'h55, 1'b0);
    release_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_en_o && tx_ready && grant_o == 3'b010) && n < 50);
    chk("to_lane1_xfer", 32'(tx_en_o && tx_ready && grant_o == 3'b010), 32'd1);
    load(0, 8'h77, 1'b1);
    bad_t = 0;
    repeat (TO) begin
      @(negedge clk);
      if (timeout_o) bad_t++;
    end
    chk("to_early", 32'(bad_t), 32'd0);
    chk("to_held_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_idle", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_o), 32'd0);
    wait_drain("to_drain", 50);

    // Backpressure: tx_ready held low mid-message.
    start_reset();
    mode = 1;
    load(0, 8'hE0, 1'b0); load(0, 8'hE1, 1'b0); load(0, 8'hE2, 1'b0); load(0, 8'hE3, 1'b1);
    base = xfer_cnt;
    release_reset();
    wait_xfers("bp_two_bytes", base + 2);
    mode = 0;
    @(negedge clk);
    snap_d = data_o;
    snap_g = grant_o;
    chk("bp_tx_en", 32'(tx_en_o), 32'd1);
    chk("bp_data_held", 32'(snap_d), 32'hE2);
    bad_d = 0; bad_g = 0; bad_r = 0; bad_t = 0;
    repeat (20) begin
      @(negedge clk);
      if (data_o != snap_d) bad_d++;
      if (grant_o != snap_g) bad_g++;
      if (req_ready_o != '0) bad_r++;
      if (timeout_o) bad_t++;
    end
    chk("bp_data_stable", 32'(bad_d), 32'd0);
    chk("bp_grant_stable", 32'(bad_g), 32'd0);
    chk("bp_ready_low", 32'(bad_r), 32'd0);
    chk("bp_no_timeout", 32'(bad_t), 32'd0);
    mode = 1;
    wait_drain("bp_drain", 50);

    // Reset after byte 2 of 5, then lane 0 must win over lane 1 again.
    start_reset();
    mode = 1;
    load(0, 8'hC0, 1'b0); load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b0);
    load(0, 8'hC3, 1'b0); load(0, 8'hC4, 1'b1);
    base = xfer_cnt;
    release_reset();
    wait_xfers("rm_two_bytes", base + 2);
    #1;
    reset = 1'b1;
    flush_req++;
    @(negedge clk);
    chk_zero("rm");
    release_reset();
    repeat (2) @(posedge clk);
    load(0, 8'hD0, 1'b1);
    load(1, 8'hD1, 1'b1);
    wait_drain("rm_prio_drain", 50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
